// File: rtl/v_tile_pkg.sv
// Shared types and config-word layout for the v_tile vector ALU tile.
package v_tile_pkg;

  typedef enum logic [1:0] {
    OP_PAIR = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MAX  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  localparam int CFG_OP_LSB   = 0;
  localparam int CFG_OP_MSB   = 1;
  localparam int CFG_SAT_BIT  = 2;
  localparam int CFG_DEST_LSB = 3;

endpackage

// File: rtl/v_lane_alu.sv
// Single-lane unsigned ALU: add/sub with optional saturation, max; reports carry/borrow.
module v_lane_alu
  import v_tile_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  op_e              op,
  input  logic             sat,
  output logic [width-1:0] y,
  output logic             ovf
);

  logic [width:0] sum_s;
  logic [width:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Lane result select; the MSB of the widened sum/diff is the carry/borrow.
  always_comb begin
    y   = {width{1'b0}};
    ovf = 1'b0;
    case (op)
      OP_PAIR, OP_ADD: begin
        ovf = sum_s[width];
        if (sat && sum_s[width]) begin
          y = {width{1'b1}};
        end else begin
          y = sum_s[width-1:0];
        end
      end
      OP_SUB: begin
        ovf = diff_s[width];
        if (sat && diff_s[width]) begin
          y = {width{1'b0}};
        end else begin
          y = diff_s[width-1:0];
        end
      end
      OP_MAX: begin
        ovf = 1'b0;
        if (a > b) begin
          y = a;
        end else begin
          y = b;
        end
      end
      default: begin
        y   = {width{1'b0}};
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/v_tile_mo.sv
// Vector ALU tile: captures vectors A, B and a sticky config word, then computes
// one registered vector result per start request and holds it until consumed.
module v_tile_mo
  import v_tile_pkg::*;
#(
  parameter  int width      = 16,
  parameter  int num_inputs = 4,
  parameter  int num_regs   = 16,
  localparam int DW         = $clog2(num_regs)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                on_off,
  input  logic                                write_en1,
  output logic                                write_rdy1,
  output logic                                write_ack1,
  input  logic [num_inputs-1:0][width-1:0]    w_data_in1,
  input  logic                                write_en2,
  output logic                                write_rdy2,
  output logic                                write_ack2,
  input  logic [num_inputs-1:0][width-1:0]    w_data_in2,
  input  logic                                write_en3,
  output logic                                write_rdy3,
  output logic                                write_ack3,
  input  logic [width-1:0]                    w_data_in3,
  output logic [num_inputs-1:0][width-1:0]    adder_outputs,
  output logic [DW-1:0]                       dest_info,
  output logic                                adder_ack,
  input  logic                                result_ready,
  output logic                                ovf_flag
);

  localparam int half    = num_inputs / 2;
  localparam int cfg_w   = CFG_DEST_LSB + DW;

  state_e                           state_r;
  logic [num_inputs-1:0][width-1:0] a_r;
  logic [num_inputs-1:0][width-1:0] b_r;
  logic [cfg_w-1:0]                 cfg_r;
  logic                             a_full_r;
  logic                             b_full_r;
  logic                             cfg_full_r;
  op_e                              op_r;
  logic                             sat_r;
  logic [DW-1:0]                    dest_r;

  logic                             idle_s;
  logic                             start_s;
  logic                             cap1_s;
  logic                             cap2_s;
  logic                             cap3_s;
  logic [num_inputs-1:0][width-1:0] lane_y_s;
  logic [num_inputs-1:0]            lane_ovf_s;
  logic                             cfg_unused_s;

  // Reserved config bits above the dest field carry no meaning.
  assign cfg_unused_s = ^w_data_in3[width-1:cfg_w];

  assign idle_s     = (state_r == ST_IDLE);
  assign write_rdy1 = idle_s && !a_full_r;
  assign write_rdy2 = idle_s && !b_full_r;
  assign write_rdy3 = idle_s;
  assign cap1_s     = write_en1 && write_rdy1;
  assign cap2_s     = write_en2 && write_rdy2;
  assign cap3_s     = write_en3 && write_rdy3;
  assign start_s    = idle_s && on_off && a_full_r && b_full_r && cfg_full_r;

  // Pairwise mode folds adjacent A elements into the low lanes and B into the high lanes.
  for (genvar i = 0; i < num_inputs; i++) begin : g_lane
    logic [width-1:0] pa_s;
    logic [width-1:0] pb_s;
    logic [width-1:0] la_s;
    logic [width-1:0] lb_s;

    if (i < half) begin : g_lo
      assign pa_s = a_r[2*i];
      assign pb_s = a_r[2*i+1];
    end else begin : g_hi
      assign pa_s = b_r[2*(i-half)];
      assign pb_s = b_r[2*(i-half)+1];
    end

    assign la_s = (op_r == OP_PAIR) ? pa_s : a_r[i];
    assign lb_s = (op_r == OP_PAIR) ? pb_s : b_r[i];

    v_lane_alu #(.width(width)) u_alu (
      .a   (la_s),
      .b   (lb_s),
      .op  (op_r),
      .sat (sat_r),
      .y   (lane_y_s[i]),
      .ovf (lane_ovf_s[i])
    );
  end

  // Slot capture, ack pulses and the IDLE/COMPUTE/DONE sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      a_r           <= '0;
      b_r           <= '0;
      cfg_r         <= {cfg_w{1'b0}};
      a_full_r      <= 1'b0;
      b_full_r      <= 1'b0;
      cfg_full_r    <= 1'b0;
      op_r          <= OP_PAIR;
      sat_r         <= 1'b0;
      dest_r        <= {DW{1'b0}};
      write_ack1    <= 1'b0;
      write_ack2    <= 1'b0;
      write_ack3    <= 1'b0;
      adder_outputs <= '0;
      dest_info     <= {DW{1'b0}};
      adder_ack     <= 1'b0;
      ovf_flag      <= 1'b0;
    end else begin
      write_ack1 <= cap1_s;
      write_ack2 <= cap2_s;
      write_ack3 <= cap3_s;
      if (cap1_s) begin
        a_r      <= w_data_in1;
        a_full_r <= 1'b1;
      end
      if (cap2_s) begin
        b_r      <= w_data_in2;
        b_full_r <= 1'b1;
      end
      if (cap3_s) begin
        cfg_r      <= w_data_in3[cfg_w-1:0];
        cfg_full_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          // Snapshot uses the pre-edge cfg, so a same-cycle cfg write waits for the next op.
          if (start_s) begin
            op_r    <= op_e'(cfg_r[CFG_OP_MSB:CFG_OP_LSB]);
            sat_r   <= cfg_r[CFG_SAT_BIT];
            dest_r  <= cfg_r[CFG_DEST_LSB +: DW];
            state_r <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          adder_outputs <= lane_y_s;
          ovf_flag      <= |lane_ovf_s;
          dest_info     <= dest_r;
          adder_ack     <= 1'b1;
          state_r       <= ST_DONE;
        end
        ST_DONE: begin
          if (result_ready) begin
            adder_ack <= 1'b0;
            a_full_r  <= 1'b0;
            b_full_r  <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_tile_mo.sv
// Directed self-checking bench for v_tile_mo with hand-computed expected vectors.
module tb_v_tile_mo;

  logic              clk = 1'b0;
  logic              reset, on_off, result_ready;
  logic              write_en1, write_en2, write_en3;
  logic              write_rdy1, write_rdy2, write_rdy3;
  logic              write_ack1, write_ack2, write_ack3;
  logic [3:0][15:0]  w_data_in1, w_data_in2, adder_outputs;
  logic [15:0]       w_data_in3;
  logic [3:0]        dest_info;
  logic              adder_ack, ovf_flag;

  int n_checks = 0;
  int n_fails  = 0;
  int lat;

  always #5 clk = ~clk;

  v_tile_mo dut (
    .clk(clk), .reset(reset), .on_off(on_off),
    .write_en1(write_en1), .write_rdy1(write_rdy1), .write_ack1(write_ack1), .w_data_in1(w_data_in1),
    .write_en2(write_en2), .write_rdy2(write_rdy2), .write_ack2(write_ack2), .w_data_in2(w_data_in2),
    .write_en3(write_en3), .write_rdy3(write_rdy3), .write_ack3(write_ack3), .w_data_in3(w_data_in3),
    .adder_outputs(adder_outputs), .dest_info(dest_info), .adder_ack(adder_ack),
    .result_ready(result_ready), .ovf_flag(ovf_flag)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write A, B (and optionally cfg) together, start, and wait a bounded time for adder_ack.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic wr_cfg,
                       input logic [15:0] cfg, output int lat_o);
    write_en1 = 1'b1; w_data_in1 = a;
    write_en2 = 1'b1; w_data_in2 = b;
    write_en3 = wr_cfg; w_data_in3 = cfg;
    tick();
    write_en1 = 1'b0; write_en2 = 1'b0; write_en3 = 1'b0;
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    lat_o = 1;
    while (!adder_ack && lat_o < 10) begin
      tick();
      lat_o++;
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_out"}, adder_outputs, 64'h0);
    check_val({tag, "_dest"}, {60'h0, dest_info}, 64'h0);
    check_val({tag, "_ovf"}, {63'h0, ovf_flag}, 64'h0);
    check_val({tag, "_ack"}, {63'h0, adder_ack}, 64'h0);
    check_val({tag, "_wacks"}, {61'h0, write_ack1, write_ack2, write_ack3}, 64'h0);
    check_val({tag, "_rdys"}, {61'h0, write_rdy1, write_rdy2, write_rdy3}, 64'h7);
  endtask

  initial begin
    reset = 1'b1; on_off = 1'b0; result_ready = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0; write_en3 = 1'b0;
    w_data_in1 = '0; w_data_in2 = '0; w_data_in3 = 16'h0;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("rst");

    // Pairwise add; all three writes in one cycle, acks pulse exactly once.
    write_en1 = 1'b1; w_data_in1 = 64'h0007_0005_0003_0001;
    write_en2 = 1'b1; w_data_in2 = 64'h0008_0006_0004_0002;
    write_en3 = 1'b1; w_data_in3 = 16'h0000;
    tick();
    check_val("acks_together", {61'h0, write_ack1, write_ack2, write_ack3}, 64'h7);
    write_en1 = 1'b0; write_en2 = 1'b0; write_en3 = 1'b0;
    tick();
    check_val("acks_one_cycle", {61'h0, write_ack1, write_ack2, write_ack3}, 64'h0);
    check_val("rdy_after_fill", {61'h0, write_rdy1, write_rdy2, write_rdy3}, 64'h1);
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    check_val("pair_ack_lat1", {63'h0, adder_ack}, 64'h0);
    tick();
    check_val("pair_ack_lat2", {63'h0, adder_ack}, 64'h1);
    check_val("pair_out", adder_outputs, 64'h000E_0006_000C_0004);
    check_val("pair_dest", {60'h0, dest_info}, 64'h0);
    check_val("pair_ovf", {63'h0, ovf_flag}, 64'h0);
    release_result();
    check_val("pair_release_ack", {63'h0, adder_ack}, 64'h0);

    // Saturating add, dest 5.
    do_op(64'h0000_8000_0001_FFFF, 64'h0000_8000_0001_0001, 1'b1, 16'h002D, lat);
    check_val("addsat_lat", lat, 64'd2);
    check_val("addsat_out", adder_outputs, 64'h0000_FFFF_0002_FFFF);
    check_val("addsat_ovf", {63'h0, ovf_flag}, 64'h1);
    check_val("addsat_dest", {60'h0, dest_info}, 64'h5);
    release_result();

    // Wrapping add.
    do_op(64'h0000_8000_0001_FFFF, 64'h0000_8000_0001_0001, 1'b1, 16'h0029, lat);
    check_val("addwrap_out", adder_outputs, 64'h0000_0000_0002_0000);
    check_val("addwrap_ovf", {63'h0, ovf_flag}, 64'h1);
    release_result();

    // Subtract with borrow, wrapping then saturating.
    do_op(64'h5, 64'h7, 1'b1, 16'h0002, lat);
    check_val("subwrap_out", adder_outputs, 64'h0000_0000_0000_FFFE);
    check_val("subwrap_ovf", {63'h0, ovf_flag}, 64'h1);
    release_result();
    do_op(64'h5, 64'h7, 1'b1, 16'h0006, lat);
    check_val("subsat_out", adder_outputs, 64'h0);
    check_val("subsat_ovf", {63'h0, ovf_flag}, 64'h1);
    release_result();

    // Unsigned max never flags overflow.
    do_op(64'hFFFF_8000_0009_0001, 64'h0000_7FFF_0003_0002, 1'b1, 16'h0003, lat);
    check_val("max_out", adder_outputs, 64'hFFFF_8000_0009_0002);
    check_val("max_ovf", {63'h0, ovf_flag}, 64'h0);
    release_result();

    // Hold in DONE for 5 cycles with a sub/dest 10 result.
    do_op(64'h0004_0003_0002_0010, 64'h0001_0001_0001_0001, 1'b1, 16'h0052, lat);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_ack", {63'h0, adder_ack}, 64'h1);
      check_val("hold_out", adder_outputs, 64'h0003_0002_0001_000F);
      check_val("hold_rdys", {61'h0, write_rdy1, write_rdy2, write_rdy3}, 64'h0);
      tick();
    end
    release_result();
    check_val("rel_ack", {63'h0, adder_ack}, 64'h0);
    check_val("rel_rdy12", {62'h0, write_rdy1, write_rdy2}, 64'h3);

    // Sticky cfg reused without a cfg write.
    do_op(64'h1, 64'h2, 1'b0, 16'h0000, lat);
    check_val("sticky_out", adder_outputs, 64'h0000_0000_0000_FFFF);
    check_val("sticky_ovf", {63'h0, ovf_flag}, 64'h1);
    check_val("sticky_dest", {60'h0, dest_info}, 64'hA);
    release_result();

    // cfg write in the start cycle only affects the following op.
    write_en1 = 1'b1; w_data_in1 = 64'h3;
    write_en2 = 1'b1; w_data_in2 = 64'h1;
    tick();
    write_en1 = 1'b0; write_en2 = 1'b0;
    on_off = 1'b1; write_en3 = 1'b1; w_data_in3 = 16'h0001;
    tick();
    on_off = 1'b0; write_en3 = 1'b0;
    tick();
    check_val("samecyc_out", adder_outputs, 64'h2);
    check_val("samecyc_dest", {60'h0, dest_info}, 64'hA);
    release_result();
    do_op(64'h3, 64'h1, 1'b0, 16'h0000, lat);
    check_val("newcfg_out", adder_outputs, 64'h4);
    check_val("newcfg_dest", {60'h0, dest_info}, 64'h0);
    release_result();

    // Start requested with B empty waits for B.
    write_en1 = 1'b1; w_data_in1 = 64'h0001_0001_0001_0001;
    tick();
    write_en1 = 1'b0;
    on_off = 1'b1;
    tick(); tick(); tick();
    check_val("noB_idle", {61'h0, write_rdy1, write_rdy2, write_rdy3}, 64'h3);
    check_val("noB_ack", {63'h0, adder_ack}, 64'h0);
    write_en2 = 1'b1; w_data_in2 = 64'h0002_0002_0002_0002;
    tick();
    write_en2 = 1'b0;
    tick();
    on_off = 1'b0;
    tick();
    check_val("lateB_ack", {63'h0, adder_ack}, 64'h1);
    check_val("lateB_out", adder_outputs, 64'h0003_0003_0003_0003);
    release_result();

    // Reset in COMPUTE.
    write_en1 = 1'b1; w_data_in1 = 64'h0005_0005_0005_0005;
    write_en2 = 1'b1; w_data_in2 = 64'h0001_0001_0001_0001;
    tick();
    write_en1 = 1'b0; write_en2 = 1'b0;
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_compute");

    // Reset in DONE.
    do_op(64'h0000_8000_0001_FFFF, 64'h0000_8000_0001_0001, 1'b1, 16'h002D, lat);
    check_val("pre_rst_ack", {63'h0, adder_ack}, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_done");

    // cfg was cleared: A and B alone cannot start an op.
    write_en1 = 1'b1; w_data_in1 = 64'h1;
    write_en2 = 1'b1; w_data_in2 = 64'h1;
    tick();
    write_en1 = 1'b0; write_en2 = 1'b0;
    on_off = 1'b1;
    tick(); tick(); tick(); tick();
    on_off = 1'b0;
    check_val("nocfg_ack", {63'h0, adder_ack}, 64'h0);
    check_val("nocfg_idle", {63'h0, write_rdy3}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
